// File: rtl/generic_service_pkg.sv
// Shared constants, FSM state type and helpers for the generic service controller.
// Register offsets are word indices taken from PADDR[4:2].
package generic_service_pkg;

  localparam int GSC_MAX_LINES = 32;

  localparam logic [2:0] GSC_REG_ENABLE        = 3'd0;
  localparam logic [2:0] GSC_REG_PENDING       = 3'd1;
  localparam logic [2:0] GSC_REG_SET_PENDING   = 3'd2;
  localparam logic [2:0] GSC_REG_CLEAR_PENDING = 3'd3;
  localparam logic [2:0] GSC_REG_MODE          = 3'd4;
  localparam logic [2:0] GSC_REG_ACTIVE        = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } gsc_state_e;

  function automatic int gsc_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gsc_prio_enc.sv
// Combinational lowest-index-first priority encoder.
// o_idx is 0 when no request is present.
module gsc_prio_enc
  import generic_service_pkg::*;
#(
  parameter  int N = GSC_MAX_LINES,
  localparam int W = gsc_id_w(N)
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [W-1:0] o_idx
);

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    // Scan downwards so the lowest set index is the last one to win.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/generic_service_ctrl.sv
// APB interrupt/event controller: per-line edge/level capture into PENDING,
// lowest-index arbitration and a held request/ID until the core acknowledges it.
module generic_service_ctrl
  import generic_service_pkg::*;
#(
  parameter  int APB_ADDR_WIDTH = 12,
  parameter  int NUM_LINES      = 32,
  localparam int ID_W           = gsc_id_w(NUM_LINES)
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_LINES-1:0]      signal_i,
  input  logic                      core_sleeping_i,
  output logic                      irq_req_o,
  output logic [ID_W-1:0]           irq_id_o,
  input  logic                      irq_ack_i,
  output logic                      wakeup_o
);

  logic [NUM_LINES-1:0] r_enable;
  logic [NUM_LINES-1:0] r_pending;
  logic [NUM_LINES-1:0] r_mode;
  logic [NUM_LINES-1:0] r_sig_q;
  gsc_state_e           r_state;
  logic                 r_irq_req;
  logic [ID_W-1:0]      r_id;
  logic                 r_wakeup;

  logic                 w_access;
  logic [2:0]           w_sel;
  logic                 w_err;
  logic                 w_wr;
  logic [NUM_LINES-1:0] w_wdata;
  logic [NUM_LINES-1:0] w_hw_set;
  logic [NUM_LINES-1:0] w_sw_set;
  logic [NUM_LINES-1:0] w_sw_clr;
  logic                 w_pend_wr;
  logic                 w_ack;
  logic [NUM_LINES-1:0] w_ack_clr;
  logic [NUM_LINES-1:0] w_pending_next;
  logic [NUM_LINES-1:0] w_cand;
  logic                 w_cand_valid;
  logic [ID_W-1:0]      w_cand_idx;
  logic [31:0]          w_rdata;
  logic                 w_unused_addr;

  assign w_unused_addr = &{1'b0, PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  assign w_access = PSEL & PENABLE;
  assign w_sel    = PADDR[4:2];
  assign w_err    = w_access & (w_sel > GSC_REG_ACTIVE);
  assign w_wr     = w_access & PWRITE & ~w_err;
  assign w_wdata  = PWDATA[NUM_LINES-1:0];

  assign w_hw_set = r_enable & ((signal_i & ~r_mode) | (signal_i & ~r_sig_q & r_mode));
  assign w_sw_set = (w_wr && (w_sel == GSC_REG_SET_PENDING))   ? w_wdata : '0;
  assign w_sw_clr = (w_wr && (w_sel == GSC_REG_CLEAR_PENDING)) ? w_wdata : '0;
  assign w_pend_wr = w_wr && (w_sel == GSC_REG_PENDING);

  assign w_ack     = (r_state == REQ) & irq_ack_i;
  assign w_ack_clr = w_ack ? (NUM_LINES'(1) << r_id) : '0;

  // Hardware set is ORed after the ack mask so a coincident event re-pends the line.
  assign w_pending_next = w_pend_wr ? (w_wdata | w_hw_set)
                                    : (((r_pending & ~w_ack_clr) | w_hw_set | w_sw_set) & ~w_sw_clr);

  assign w_cand = r_pending & r_enable;

  gsc_prio_enc #(
    .N (NUM_LINES)
  ) u_prio (
    .i_req   (w_cand),
    .o_valid (w_cand_valid),
    .o_idx   (w_cand_idx)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_enable  <= '0;
      r_pending <= '0;
      r_mode    <= '0;
      r_sig_q   <= '0;
      r_wakeup  <= 1'b0;
    end else begin
      r_sig_q   <= signal_i;
      r_pending <= w_pending_next;
      r_wakeup  <= core_sleeping_i & w_cand_valid;
      if (w_wr && (w_sel == GSC_REG_ENABLE)) begin
        r_enable <= w_wdata;
      end
      if (w_wr && (w_sel == GSC_REG_MODE)) begin
        r_mode <= w_wdata;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state   <= IDLE;
      r_irq_req <= 1'b0;
      r_id      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cand_valid) begin
            r_id      <= w_cand_idx;
            r_state   <= REQ;
            r_irq_req <= 1'b1;
          end
        end
        REQ: begin
          // An ack wins over withdrawal; either way the line is released.
          if (irq_ack_i || !r_pending[r_id] || !r_enable[r_id]) begin
            r_state   <= IDLE;
            r_irq_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_irq_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_access && !PWRITE && !w_err) begin
      case (w_sel)
        GSC_REG_ENABLE:  w_rdata = 32'(r_enable);
        GSC_REG_PENDING: w_rdata = 32'(r_pending);
        GSC_REG_MODE:    w_rdata = 32'(r_mode);
        GSC_REG_ACTIVE: begin
          if (r_state == REQ) begin
            w_rdata[31]       = 1'b1;
            w_rdata[ID_W-1:0] = r_id;
          end
        end
        default:         w_rdata = '0;
      endcase
    end
  end

  assign PRDATA    = w_rdata;
  assign PREADY    = 1'b1;
  assign PSLVERR   = w_err;
  assign irq_req_o = r_irq_req;
  assign irq_id_o  = r_id;
  assign wakeup_o  = r_wakeup;

endmodule

// File: tb/tb_generic_service_ctrl.sv
// Directed bench for generic_service_ctrl: a 32-line instance for the main flows
// and a 5-line instance for parameter masking and wake behaviour.
module tb_generic_service_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic        psel_a;
  logic        psel_b;

  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;

  logic [31:0] sig_a;
  logic [4:0]  sig_b;
  logic        sleeping;
  logic        ack_a;
  logic        ack_b;
  logic        req_a, req_b, wake_a, wake_b;
  logic [4:0]  id_a;
  logic [2:0]  id_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rd;
  logic        er;

  always #5 HCLK = ~HCLK;

  generic_service_ctrl #(.APB_ADDR_WIDTH(12), .NUM_LINES(32)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(psel_a), .PENABLE(PENABLE),
    .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a),
    .signal_i(sig_a), .core_sleeping_i(sleeping),
    .irq_req_o(req_a), .irq_id_o(id_a), .irq_ack_i(ack_a), .wakeup_o(wake_a)
  );

  generic_service_ctrl #(.APB_ADDR_WIDTH(12), .NUM_LINES(5)) u_dut5 (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(psel_b), .PENABLE(PENABLE),
    .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b),
    .signal_i(sig_b), .core_sleeping_i(sleeping),
    .irq_req_o(req_b), .irq_id_o(id_b), .irq_ack_i(ack_b), .wakeup_o(wake_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge HCLK);
  endtask

  // Called at a negedge; returns at the negedge after the access-phase edge.
  task automatic apb_write(input logic tgt, input logic [11:0] addr, input logic [31:0] data);
    psel_a  = ~tgt;
    psel_b  = tgt;
    PADDR   = addr;
    PWDATA  = data;
    PWRITE  = 1'b1;
    PENABLE = 1'b0;
    step();
    PENABLE = 1'b1;
    step();
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    $display("apb wr dut%0d addr 0x%03h data 0x%08h", tgt ? 5 : 32, addr, data);
  endtask

  task automatic apb_read(input logic tgt, input logic [11:0] addr,
                          output logic [31:0] data, output logic err);
    psel_a  = ~tgt;
    psel_b  = tgt;
    PADDR   = addr;
    PWRITE  = 1'b0;
    PENABLE = 1'b0;
    step();
    PENABLE = 1'b1;
    #1;
    data = tgt ? prdata_b : prdata_a;
    err  = tgt ? pslverr_b : pslverr_a;
    step();
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    PENABLE = 1'b0;
    $display("apb rd dut%0d addr 0x%03h data 0x%08h err %0d", tgt ? 5 : 32, addr, data, err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PENABLE = 1'b0;
    psel_a = 1'b0; psel_b = 1'b0; sig_a = '0; sig_b = '0;
    sleeping = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
    step(); step();

    check_eq("rst_req",     32'(req_a), 32'd0);
    check_eq("rst_id",      32'(id_a), 32'd0);
    check_eq("rst_wake",    32'(wake_a), 32'd0);
    check_eq("rst_pready",  32'(pready_a), 32'd1);
    check_eq("rst_pslverr", 32'(pslverr_a), 32'd0);
    check_eq("rst_prdata",  prdata_a, 32'd0);
    HRESETn = 1'b1;
    step();

    // Level line 0
    apb_write(1'b0, 12'h010, 32'h0);
    apb_write(1'b0, 12'h000, 32'h1);
    sig_a = 32'h1;
    step();
    check_eq("lvl_req_k0", 32'(req_a), 32'd0);
    step();
    check_eq("lvl_req_k1", 32'(req_a), 32'd1);
    check_eq("lvl_id",     32'(id_a), 32'd0);
    ack_a = 1'b1; step(); ack_a = 1'b0;
    check_eq("lvl_gap",    32'(req_a), 32'd0);
    step();
    check_eq("lvl_rearm",  32'(req_a), 32'd1);
    ack_a = 1'b1; sig_a = '0; step(); ack_a = 1'b0;
    check_eq("lvl_done",   32'(req_a), 32'd0);
    apb_read(1'b0, 12'h004, rd, er);
    check_eq("lvl_pend",   rd, 32'h0);

    // Edge priority: lines 5 and 4 pulse together
    apb_write(1'b0, 12'h010, 32'hFFFF_FFFF);
    apb_write(1'b0, 12'h000, 32'h30);
    sig_a = 32'h30; step(); sig_a = '0; step();
    check_eq("edg_req1", 32'(req_a), 32'd1);
    check_eq("edg_id1",  32'(id_a), 32'd4);
    ack_a = 1'b1; step(); ack_a = 1'b0;
    check_eq("edg_gap",  32'(req_a), 32'd0);
    step();
    check_eq("edg_req2", 32'(req_a), 32'd1);
    check_eq("edg_id2",  32'(id_a), 32'd5);
    ack_a = 1'b1; step(); ack_a = 1'b0;
    check_eq("edg_idle", 32'(req_a), 32'd0);
    apb_read(1'b0, 12'h004, rd, er);
    check_eq("edg_pend", rd, 32'h0);

    // Coincident edge and ack on line 3
    apb_write(1'b0, 12'h000, 32'h08);
    sig_a = 32'h08; step(); sig_a = '0; step();
    check_eq("coi_req1", 32'(req_a), 32'd1);
    check_eq("coi_id1",  32'(id_a), 32'd3);
    ack_a = 1'b1; sig_a = 32'h08; step(); ack_a = 1'b0; sig_a = '0;
    check_eq("coi_gap",  32'(req_a), 32'd0);
    step();
    check_eq("coi_req2", 32'(req_a), 32'd1);
    check_eq("coi_id2",  32'(id_a), 32'd3);
    apb_read(1'b0, 12'h004, rd, er);
    check_eq("coi_pend", rd, 32'h08);
    ack_a = 1'b1; step(); ack_a = 1'b0;
    apb_read(1'b0, 12'h004, rd, er);
    check_eq("coi_pend0", rd, 32'h0);

    // Software set / clear and error responses
    apb_write(1'b0, 12'h000, 32'h80);
    apb_write(1'b0, 12'h008, 32'h80);
    check_eq("sw_req_k0", 32'(req_a), 32'd0);
    step();
    check_eq("sw_req_k1", 32'(req_a), 32'd1);
    check_eq("sw_id",     32'(id_a), 32'd7);
    apb_read(1'b0, 12'h014, rd, er);
    check_eq("sw_active", rd, 32'h8000_0007);
    apb_read(1'b0, 12'h008, rd, er);
    check_eq("sw_setrd",  rd, 32'h0);
    apb_write(1'b0, 12'h00C, 32'h80);
    check_eq("sw_clr_k0", 32'(req_a), 32'd1);
    step();
    check_eq("sw_withdraw", 32'(req_a), 32'd0);
    apb_read(1'b0, 12'h014, rd, er);
    check_eq("sw_active0", rd, 32'h0);
    apb_read(1'b0, 12'h004, rd, er);
    check_eq("sw_pend0",  rd, 32'h0);
    apb_read(1'b0, 12'h018, rd, er);
    check_eq("err_18_slverr", 32'(er), 32'd1);
    check_eq("err_18_data",   rd, 32'h0);
    apb_read(1'b0, 12'h000, rd, er);
    check_eq("ok_00_slverr",  32'(er), 32'd0);
    check_eq("ok_00_data",    rd, 32'h80);

    // 5-line instance: masking and wake
    apb_write(1'b1, 12'h004, 32'hFFFF_FFFF);
    apb_read(1'b1, 12'h004, rd, er);
    check_eq("p5_pend", rd, 32'h1F);
    sleeping = 1'b1;
    step();
    check_eq("p5_wake_dis", 32'(wake_b), 32'd0);
    apb_write(1'b1, 12'h000, 32'h1);
    check_eq("p5_wake_k0", 32'(wake_b), 32'd0);
    step();
    check_eq("p5_wake_k1", 32'(wake_b), 32'd1);
    check_eq("p5_req",     32'(req_b), 32'd1);
    check_eq("p5_id",      32'(id_b), 32'd0);
    check_eq("main_wake",  32'(wake_a), 32'd0);
    sleeping = 1'b0;

    // Reset in the middle of a request
    apb_write(1'b0, 12'h008, 32'h80);
    step();
    check_eq("mr_req",  32'(req_a), 32'd1);
    HRESETn = 1'b0;
    step();
    check_eq("mr_req0",  32'(req_a), 32'd0);
    check_eq("mr_id0",   32'(id_a), 32'd0);
    check_eq("mr_wake0", 32'(wake_a), 32'd0);
    check_eq("mr_req5",  32'(req_b), 32'd0);
    HRESETn = 1'b1;
    apb_read(1'b0, 12'h000, rd, er);
    check_eq("mr_enable", rd, 32'h0);
    apb_read(1'b0, 12'h004, rd, er);
    check_eq("mr_pend",   rd, 32'h0);
    apb_read(1'b0, 12'h010, rd, er);
    check_eq("mr_mode",   rd, 32'h0);
    apb_read(1'b0, 12'h014, rd, er);
    check_eq("mr_active", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
